// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters/FIFO (master) and the round-robin
// write-port arbiter (slave).
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic                    arb_en;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    fifo_wr_full;
    logic                    fifo_wr_en;
    logic [WIDTH-1:0]        fifo_wr_data;
    logic [IDW-1:0]          fifo_wr_id;
    logic                    busy;
    logic [15:0]             word_count;

    modport master (
        output arb_en, req_valid, req_data, fifo_wr_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_id, busy, word_count
    );

    modport slave (
        input  arb_en, req_valid, req_data, fifo_wr_full,
        output req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_id, busy, word_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between NREQ
// valid/ready requesters, granting bounded bursts and honouring the full flag.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int MAX_BURST = 8
) (
    input  logic             wr_clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [8:0]     BURST_LAST = 9'(MAX_BURST);
    localparam logic [IDW-1:0] GRANT_INIT = IDW'(NREQ - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   r_last_grant;
    logic [7:0]       r_burst_cnt;
    logic [15:0]      r_word_count;
    logic [WIDTH-1:0] r_data_hold;

    logic [WIDTH-1:0] w_data_arr [NREQ];
    logic [IDW-1:0]   w_sel;
    logic             w_found;
    logic             w_grant_valid;
    logic             w_xfer;
    logic             w_last_beat;
    logic             w_exit;
    logic [NREQ-1:0]  w_req_ready;
    logic [WIDTH-1:0] w_wr_data;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_data_arr[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end

    // Scan offsets high-to-low so the nearest requester after last_grant wins.
    always_comb begin
        int idx;
        w_sel   = r_last_grant;
        w_found = 1'b0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(r_last_grant) + k) % NREQ;
            if (bus.req_valid[idx]) begin
                w_sel   = IDW'(idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_grant_valid = bus.req_valid[r_grant];
    assign w_xfer        = (r_state == S_BURST) && w_grant_valid && !bus.fifo_wr_full;
    assign w_last_beat   = ({1'b0, r_burst_cnt} + 9'd1) == BURST_LAST;
    assign w_exit        = (w_xfer && w_last_beat) || !w_grant_valid || !bus.arb_en;

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.arb_en && w_found) w_state_next = S_BURST;
            S_BURST: if (w_exit) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            r_grant      <= '0;
            r_last_grant <= GRANT_INIT;
            r_burst_cnt  <= '0;
            r_word_count <= '0;
            r_data_hold  <= '0;
        end else begin
            if (r_state == S_IDLE && w_state_next == S_BURST) begin
                r_grant     <= w_sel;
                r_burst_cnt <= '0;
            end else if (w_xfer) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end
            if (r_state == S_BURST && w_state_next == S_IDLE) begin
                r_last_grant <= r_grant;
            end
            if (w_xfer && r_word_count != 16'hFFFF) begin
                r_word_count <= r_word_count + 16'd1;
            end
            // Keeps fifo_wr_data stable at the last granted word while idle.
            if (r_state == S_BURST) begin
                r_data_hold <= w_data_arr[r_grant];
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        w_wr_data   = r_data_hold;
        if (r_state == S_BURST) begin
            w_req_ready[r_grant] = !bus.fifo_wr_full;
            w_wr_data            = w_data_arr[r_grant];
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.fifo_wr_en   = w_xfer;
    assign bus.fifo_wr_data = w_wr_data;
    assign bus.fifo_wr_id   = r_grant;
    assign bus.busy         = (r_state == S_BURST);
    assign bus.word_count   = r_word_count;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO, running entirely in the wr_clk domain. It shares the single FIFO write port between NREQ requesters, each using a valid/ready handshake. A granted requester holds the port for a bounded burst of words. The block honours the FIFO full flag so that no word is ever written to a full FIFO, and it reports the source ID of every word written.

## Interface
- WIDTH, 8: data word width; matches FIFO data width.
- NREQ, 4: number of requesters; must be 2..8.
- IDW, 2: width of requester ID; must satisfy 2^IDW >= NREQ.
- MAX_BURST, 8: maximum words per grant; must be 1..255.
- wr_clk  in  1  write-domain clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- arb_en  in  1  arbitration enable; when low, no new grant is issued.
- req_valid  in  NREQ  per-requester word available.
- req_data  in  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  per-requester word accepted in this cycle (when qualified with valid).
- fifo_wr_full  in  1  FIFO full flag, in the wr_clk domain.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  WIDTH  word to FIFO.
- fifo_wr_id  out  IDW  ID of the requester currently granted.
- busy  out  1  high while in BURST.
- word_count  out  16  total words written; saturates at 16'hFFFF.

## Operation
- FSM has two states: IDLE and BURST. Registers: state, grant[IDW], last_grant[IDW], burst_cnt[8], word_count[16].
- IDLE:
  - If arb_en=1 and any req_valid is high, select the first asserted requester, searching from (last_grant+1) mod NREQ upward with wrap-around.
  - Load grant with that index, clear burst_cnt, go to BURST.
  - Otherwise remain in IDLE.
- BURST:
  - req_ready[grant] = ~fifo_wr_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant] & ~fifo_wr_full.
  - fifo_wr_data = req_data[grant]. fifo_wr_id = grant.
- A transfer occurs on any BURST cycle with fifo_wr_en=1. On a transfer, burst_cnt and word_count increment (word_count saturates).
- BURST exits to IDLE at the clock edge when any of the following holds; on exit, last_grant <= grant:
  - a transfer with burst_cnt+1 == MAX_BURST;
  - req_valid[grant]=0;
  - arb_en=0.
- While fifo_wr_full=1 and req_valid[grant]=1, the FSM stays in BURST and stalls with no timeout. burst_cnt does not advance during the stall.
- In IDLE, all req_ready bits are 0, fifo_wr_en=0, and fifo_wr_data/fifo_wr_id hold the value from the last grant. These outputs are don't-care for the FIFO.
- A requester dropping valid mid-burst forfeits the rest of its burst. It is re-arbitrated in normal round-robin order.
- Unused ID codes (grant >= NREQ) are unreachable.

## Timing
- Reset values:
  - state=IDLE; grant=0; last_grant=NREQ-1, so requester 0 has first priority after reset.
  - burst_cnt=0; word_count=0.
  - req_ready=0, fifo_wr_en=0, busy=0; fifo_wr_data and fifo_wr_id are 0.
- Reset asserted mid-burst clears everything immediately. Any word whose edge coincides with reset is not counted and is not written.
- Arbitration latency: req_valid sampled high in IDLE at edge N gives BURST from edge N, with first transfer possible in cycle N+1.
- Each grant therefore costs one IDLE bubble cycle. Peak throughput is MAX_BURST/(MAX_BURST+1) words per cycle.
- req_ready and fifo_wr_en are combinational from state, fifo_wr_full and req_valid. There is no registered lag on full, so overflow is impossible provided fifo_wr_full is valid in the same cycle.
- busy is a direct decode of state==BURST.

## Test plan
- Reset and single requester:
  - Stimulus: after reset, req_valid=4'b0001, MAX_BURST=8, FIFO never full.
  - Required: first fifo_wr_en one cycle after valid is sampled; 8 consecutive writes with id=0; one IDLE cycle; a second burst for requester 0; word_count=16 after 18 cycles.
- Round-robin fairness:
  - Stimulus: all four requesters continuously valid.
  - Required: grant order is 0,1,2,3,0. Each burst is exactly 8 writes separated by one idle cycle. word_count=32 after 36 cycles.
- Full stall:
  - Stimulus: during a burst on requester 2, assert fifo_wr_full for 5 cycles after the 3rd word.
  - Required: fifo_wr_en=0 and req_ready[2]=0 for those 5 cycles; the burst resumes and ends after 8 total words.
- Early release and skip:
  - Stimulus: requester 1 drops valid after 3 words; requester 3 is valid, requester 2 is idle.
  - Required: BURST exits after 3 words; the next grant goes to requester 3, skipping 2.
- Disable and reset mid-operation:
  - Stimulus: drop arb_en mid-burst; then assert reset during a later burst.
  - Required: the current burst ends and no new grant is issued while arb_en=0. After reset, all outputs are zero and the first grant goes to requester 0.
- Saturation:
  - Stimulus: preload or run until word_count=16'hFFFE, then perform 3 more writes.
  - Required: word_count stops at 16'hFFFF.
